// File: rtl/dma_copy_arbiter.sv
// Single-port memory front end shared between a CPU requester and a block-copy engine.
// Round-robin arbitration per slot; the reserved status word is never written.
module dma_copy_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int RSVD_ADDR = 191,
    parameter int MAX_LEN   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [7:0]        len,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SW = ADDR_W + 1;
    localparam logic [SW-1:0]     RSVD_X = SW'(RSVD_ADDR);
    localparam logic [ADDR_W-1:0] RSVD_A = ADDR_W'(RSVD_ADDR);
    localparam logic [7:0]        MAX_L  = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] src_q, dst_q;
    logic [7:0]        rem_q;
    logic [DATA_W-1:0] buf_q;
    logic              err_q;
    logic              last_dma;
    logic              rvalid_q;

    logic [SW-1:0] len_x, src_lim, src_end, dst_end;
    logic          len_zero, reject;
    logic          dma_req, dma_gnt, cpu_req_g;

    // Range checks are done one bit wider than the address so sums cannot wrap.
    always_comb begin
        len_x    = SW'(len);
        src_lim  = {1'b0, src_addr} + len_x;
        src_end  = src_lim - SW'(1);
        dst_end  = {1'b0, dst_addr} + len_x - SW'(1);
        len_zero = (len == 8'd0);
        reject   = !len_zero &&
                   ((len > MAX_L) ||
                    (src_end >= RSVD_X) ||
                    (dst_end >= RSVD_X) ||
                    (({1'b0, src_addr} < {1'b0, dst_addr}) && ({1'b0, dst_addr} < src_lim)));
    end

    // Contested slot goes to whoever did not own the previous granted slot.
    always_comb begin
        dma_req   = (state == RD) || (state == WR);
        cpu_req_g = cpu_req && rst_n;
        cpu_gnt   = cpu_req_g && (!dma_req || last_dma);
        dma_gnt   = dma_req && !cpu_gnt;
    end

    always_comb begin
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_addr = cpu_addr;
            if (cpu_wr) begin
                mem_wr    = (cpu_addr != RSVD_A);
                mem_wdata = cpu_wdata;
            end
        end else if (dma_gnt) begin
            if (state == RD) begin
                mem_addr = src_q;
            end else begin
                mem_wr    = 1'b1;
                mem_addr  = dst_q;
                mem_wdata = buf_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (len_zero || reject) ? DONE : RD;
                end
            end
            RD: begin
                busy = 1'b1;
                if (dma_gnt) state_nx = CAP;
            end
            CAP: begin
                busy     = 1'b1;
                state_nx = WR;
            end
            WR: begin
                busy = 1'b1;
                if (dma_gnt) state_nx = (rem_q == 8'd1) ? DONE : RD;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q    <= '0;
            dst_q    <= '0;
            rem_q    <= '0;
            buf_q    <= '0;
            err_q    <= 1'b0;
            last_dma <= 1'b1;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= cpu_gnt && !cpu_wr;
            if (cpu_gnt || dma_gnt) last_dma <= dma_gnt;
            case (state)
                IDLE: begin
                    if (start) begin
                        err_q <= reject;
                        if (!reject && !len_zero) begin
                            src_q <= src_addr;
                            dst_q <= dst_addr;
                            rem_q <= len;
                        end
                    end
                end
                CAP: buf_q <= mem_rdata;
                WR: begin
                    if (dma_gnt) begin
                        src_q <= src_q + ADDR_W'(1);
                        dst_q <= dst_q + ADDR_W'(1);
                        rem_q <= rem_q - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign err        = err_q;
    assign cpu_rvalid = rvalid_q;
    assign cpu_rdata  = mem_rdata;

endmodule

// File: tb/tb_dma_copy_arbiter.sv
// Bench for dma_copy_arbiter: behavioural memory, write/read scoreboards, per-scenario tasks.
module tb_dma_copy_arbiter;

    localparam int RSVD = 191;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  src_addr = '0, dst_addr = '0, len = '0;
    logic        busy, done, err;
    logic        cpu_req = 1'b0, cpu_wr = 1'b0;
    logic [7:0]  cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        mem_wr;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic [31:0] mem  [0:255];
    logic [31:0] refm [0:255];
    logic [39:0] wq [$];
    logic [31:0] rq [$];
    logic [31:0] cpu_exp = '0;
    logic [39:0] mon_e;
    logic [31:0] mon_r;
    int total = 0;
    int bad = 0;
    int wr_pulses = 0;

    dma_copy_arbiter #(.ADDR_W(8), .DATA_W(32), .RSVD_ADDR(191), .MAX_LEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .len(len), .busy(busy), .done(done), .err(err), .cpu_req(cpu_req), .cpu_wr(cpu_wr),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] = mem_wdata;
        else        mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_wr) begin
                wr_pulses++;
                total++;
                if (wq.size() == 0) begin
                    bad++;
                    $display("FAIL wr_unexpected: addr=%0d data=%h, required no write", mem_addr, mem_wdata);
                end else begin
                    mon_e = wq.pop_front();
                    if ({mem_addr, mem_wdata} !== mon_e) begin
                        bad++;
                        $display("FAIL wr_data: got addr=%0d data=%h, required addr=%0d data=%h",
                                 mem_addr, mem_wdata, mon_e[39:32], mon_e[31:0]);
                    end
                end
            end
            if (busy && !cpu_gnt) begin
                total++;
                if (mem_addr === 8'(RSVD)) begin
                    bad++;
                    $display("FAIL dma_rsvd: dma addr=%0d, required anything but %0d", mem_addr, RSVD);
                end
            end
            if (cpu_rvalid) begin
                total++;
                if (rq.size() == 0) begin
                    bad++;
                    $display("FAIL rvalid_unexpected: rdata=%h, required no rvalid", cpu_rdata);
                end else begin
                    mon_r = rq.pop_front();
                    if (cpu_rdata !== mon_r) begin
                        bad++;
                        $display("FAIL cpu_rdata: got %h, required %h", cpu_rdata, mon_r);
                    end
                end
            end
            if (cpu_gnt && !cpu_wr) rq.push_back(cpu_exp);
        end
    end

    task automatic load(input logic [7:0] a, input logic [31:0] v);
        mem[a]  = v;
        refm[a] = v;
    endtask

    task automatic pulse_start(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
        @(posedge clk); #1;
        start = 1'b1; src_addr = s; dst_addr = d; len = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
        for (int i = 0; i < int'(l); i++) begin
            refm[8'(d + i)] = refm[8'(s + i)];
            wq.push_back({8'(d + i), refm[8'(s + i)]});
        end
    endtask

    task automatic check_idle_outputs(input string name);
        logic [70:0] obs;
        obs = {busy, done, err, cpu_gnt, cpu_rvalid, mem_wr, mem_addr, mem_wdata};
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL %s: outputs=%h, required all zero", name, obs);
        end
    endtask

    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                            input int exp_busy, input bit poke);
        int nbusy;
        int cyc;
        nbusy = 0;
        cyc = 0;
        push_copy(s, d, l);
        pulse_start(s, d, l);
        while (cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (poke) start = (cyc == 5);
            if (done) break;
            if (busy) nbusy++;
        end
        start = 1'b0;
        total++;
        if (!done || cyc != exp_busy + 1) begin
            bad++;
            $display("FAIL copy_done_cycle: done=%b at cycle %0d, required 1 at %0d", done, cyc, exp_busy + 1);
        end
        total++;
        if (nbusy != exp_busy) begin
            bad++;
            $display("FAIL copy_busy_cycles: got %0d, required %0d", nbusy, exp_busy);
        end
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL copy_err: got %b, required 0", err);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL done_width: done=%b one cycle later, required 0", done);
        end
        for (int i = 0; i < int'(l); i++) begin
            total++;
            if (mem[8'(d + i)] !== refm[8'(d + i)]) begin
                bad++;
                $display("FAIL copy_mem[%0d]: got %h, required %h", 8'(d + i), mem[8'(d + i)], refm[8'(d + i)]);
            end
        end
        total++;
        if (wq.size() != 0) begin
            bad++;
            $display("FAIL copy_writes_missing: %0d left, required 0", wq.size());
            wq.delete();
        end
    endtask

    task automatic test_reset();
        #2;
        check_idle_outputs("reset_outputs");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset_idle");
    endtask

    task automatic test_copy();
        load(0, 32'd8); load(1, 32'd9); load(2, 32'd12); load(3, 32'd5);
        run_copy(8'd0, 8'd100, 8'd4, 12, 1'b0);
    endtask

    task automatic test_contention();
        int cyc;
        int nbusy;
        cyc = 0;
        nbusy = 0;
        cpu_exp = 32'd12;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 8'd2;
        repeat (2) @(posedge clk);
        push_copy(8'd0, 8'd100, 8'd4);
        pulse_start(8'd0, 8'd100, 8'd4);
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done) break;
            if (busy) begin
                nbusy++;
                total++;
                if (cpu_gnt !== ((cyc % 2) == 0)) begin
                    bad++;
                    $display("FAIL contention_gnt cycle %0d: cpu_gnt=%b, required %b", cyc, cpu_gnt, (cyc % 2) == 0);
                end
            end
        end
        total++;
        if (!done || cyc != 16 || nbusy > 20) begin
            bad++;
            $display("FAIL contention_done: done=%b cycle=%0d busy=%0d, required done at 16", done, cyc, nbusy);
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (rq.size() != 0 || wq.size() != 0) begin
            bad++;
            $display("FAIL contention_drain: rq=%0d wq=%0d, required 0 0", rq.size(), wq.size());
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem[100 + i] !== refm[100 + i]) begin
                bad++;
                $display("FAIL contention_mem[%0d]: got %h, required %h", 100 + i, mem[100 + i], refm[100 + i]);
            end
        end
    endtask

    task automatic test_reject(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l, input string name);
        int w0;
        w0 = wr_pulses;
        pulse_start(s, d, l);
        @(negedge clk);
        total++;
        if ({done, err, busy} !== 3'b110) begin
            bad++;
            $display("FAIL %s: done/err/busy=%b, required 110", name, {done, err, busy});
        end
        repeat (2) @(negedge clk);
        total++;
        if (wr_pulses != w0 || done !== 1'b0 || err !== 1'b1) begin
            bad++;
            $display("FAIL %s_after: writes=%0d done=%b err=%b, required 0 0 1", name, wr_pulses - w0, done, err);
        end
    endtask

    task automatic test_rejects();
        test_reject(8'd188, 8'd0, 8'd4, "reject_src_end");
        test_reject(8'd0, 8'd190, 8'd2, "reject_dst_end");
        test_reject(8'd0, 8'd100, 8'd65, "reject_len");
        test_reject(8'd10, 8'd12, 8'd4, "reject_overlap");
    endtask

    task automatic test_len0();
        int seen;
        seen = 0;
        pulse_start(8'd5, 8'd6, 8'd0);
        @(negedge clk);
        total++;
        if ({done, err, busy} !== 3'b100) begin
            bad++;
            $display("FAIL len0: done/err/busy=%b, required 100", {done, err, busy});
        end
        repeat (3) begin
            @(negedge clk);
            if (busy || done) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL len0_quiet: busy/done seen %0d cycles, required 0", seen);
        end
    endtask

    task automatic test_reserved();
        refm[150] = 32'h1234_5678;
        wq.push_back({8'd150, 32'h1234_5678});
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 8'd150; cpu_wdata = 32'h1234_5678;
        @(negedge clk);
        total++;
        if (cpu_gnt !== 1'b1 || mem_wr !== 1'b1) begin
            bad++;
            $display("FAIL cpu_write: gnt=%b mem_wr=%b, required 1 1", cpu_gnt, mem_wr);
        end
        @(posedge clk); #1;
        cpu_addr = 8'(RSVD); cpu_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        total++;
        if (cpu_gnt !== 1'b1 || mem_wr !== 1'b0) begin
            bad++;
            $display("FAIL rsvd_write: gnt=%b mem_wr=%b, required 1 0", cpu_gnt, mem_wr);
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_wr = 1'b0;
        total++;
        if (mem[RSVD] !== 32'h5A5A_0001 || mem[150] !== 32'h1234_5678) begin
            bad++;
            $display("FAIL rsvd_mem: [191]=%h [150]=%h, required 5a5a0001 12345678", mem[RSVD], mem[150]);
        end
    endtask

    task automatic test_boundary();
        run_copy(8'd0, 8'd187, 8'd4, 12, 1'b0);
        total++;
        if (mem[RSVD] !== 32'h5A5A_0001) begin
            bad++;
            $display("FAIL boundary_rsvd: got %h, required 5a5a0001", mem[RSVD]);
        end
        for (int i = 0; i < 8; i++) load(8'(20 + i), 32'hA000_0000 + 32'(i));
        run_copy(8'd20, 8'd10, 8'd8, 24, 1'b0);
        for (int i = 0; i < 8; i++) load(8'(30 + i), 32'hB000_0000 + 32'(i * 3));
        run_copy(8'd30, 8'd26, 8'd8, 24, 1'b0);
    endtask

    task automatic test_reset_midop();
        int seen;
        seen = 0;
        for (int i = 0; i < 8; i++) load(8'(40 + i), 32'hC000_0000 + 32'(i * 7));
        push_copy(8'd40, 8'd120, 8'd8);
        pulse_start(8'd40, 8'd120, 8'd8);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_idle_outputs("midop_reset_outputs");
        total++;
        if (wq.size() != 7) begin
            bad++;
            $display("FAIL midop_partial: pending writes=%0d, required 7", wq.size());
        end
        wq.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL midop_no_done: busy/done seen %0d cycles, required 0", seen);
        end
        run_copy(8'd40, 8'd120, 8'd8, 24, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) load(8'(i), 32'h0F00_0000 + 32'(i));
        load(8'(RSVD), 32'h5A5A_0001);
        test_reset();
        test_copy();
        test_contention();
        test_rejects();
        test_len0();
        test_reserved();
        test_boundary();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
